// File: rtl/gold_pkg.sv
// Shared definitions for the Gold-code receiver.
// It holds the default code geometry, the default m-sequence feedback
// polynomials, the LFSR seed, the shift-word type and the FSM state encoding.
// There are no ports.
package gold_pkg;

  localparam int GOLD_N      = 63;
  localparam int GOLD_LENGTH = 6;

  // Fibonacci tap masks. Bit j set means reg[j] feeds the XOR.
  // 100001 realises x^6+x+1 and 110011 realises x^6+x^5+x^2+x+1
  // (in reciprocal form). Together they form a preferred pair.
  localparam logic [GOLD_LENGTH-1:0] GOLD_POLY1 = 6'b100001;
  localparam logic [GOLD_LENGTH-1:0] GOLD_POLY2 = 6'b110011;
  localparam logic [GOLD_LENGTH-1:0] GOLD_SEED  = '1;

  typedef logic [GOLD_LENGTH-1:0] shift_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    GEN
  } state_t;

endpackage

// File: rtl/axistream_if.sv
// Minimal AXI-stream bundle carrying tvalid, tready and tdata.
// Ports: none. It carries the signals only.
//   master modport : drives tvalid and tdata, and samples tready
//   slave  modport : samples tvalid and tdata, and drives tready
interface axistream_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/gold_code_receiver_lfsr.sv
// gold_lfsr: Fibonacci LFSR with synchronous load and step controls.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset. It loads SEED.
//   load_i : reload SEED (this has priority over step_i)
//   step_i : advance one position, new_bit = ^(reg & POLY), shifted in at the MSB
//   bit0_o : bit 0 that the register will hold after the coming clock edge.
//            This lets the parent register its chip output without adding a
//            pipeline stage.
module gold_lfsr #(
  parameter int                 LENGTH = 6,
  parameter logic [LENGTH-1:0]  POLY   = 6'b100001,
  parameter logic [LENGTH-1:0]  SEED   = '1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic step_i,
  output logic bit0_o
);

  logic [LENGTH-1:0] state_q, state_d;

  // The feedback is the parity of the tapped bits. The register shifts toward bit 0.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED;
    end else if (step_i) begin
      state_d = {^(state_q & POLY), state_q[LENGTH-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign bit0_o = state_d[0];

endmodule

// File: rtl/gold_code_receiver.sv
// gold_code_receiver: This block accepts shift words k over AXI-stream. For each
// legal k it emits one N-chip Gold code serially. The code is m1 XOR (m2 advanced by k).
// Ports:
//   clkin       : system clock
//   rstn        : asynchronous active-low reset
//   s_axis      : shift-word input (tvalid/tready/tdata). k = tdata[LENGTH-1:0].
//   chip        : current Gold chip
//   chip_valid  : chip is valid this cycle
//   code_start  : marks chip index 0
//   code_last   : marks chip index N-1
//   code_shift  : k of the current code. It is held until the next legal accept.
//   shift_err   : one-cycle pulse after an illegal k (k >= N) is accepted
// Optional (macro GOLD_RX_STATS_EN):
//   ones_cnt    : number of 1-chips in the code that has just finished
//   stats_valid : one-cycle pulse on the cycle after code_last
// All outputs are registered.
module gold_code_receiver
  import gold_pkg::*;
#(
  parameter int                N      = GOLD_N,
  parameter int                LENGTH = $clog2(N),
  parameter logic [LENGTH-1:0] POLY1  = GOLD_POLY1,
  parameter logic [LENGTH-1:0] POLY2  = GOLD_POLY2,
  parameter logic [LENGTH-1:0] SEED   = GOLD_SEED
) (
  input  logic              clkin,
  input  logic              rstn,
  axistream_if.slave        s_axis,
  output logic              chip,
  output logic              chip_valid,
  output logic              code_start,
  output logic              code_last,
  output logic [LENGTH-1:0] code_shift,
  output logic              shift_err
`ifdef GOLD_RX_STATS_EN
  ,
  output logic [LENGTH:0]   ones_cnt,
  output logic              stats_valid
`endif
);

  localparam logic [LENGTH-1:0] LAST_IDX = LENGTH'(N - 1);

  state_t            state_q, state_d;
  logic [LENGTH-1:0] cnt_q, cnt_d;
  logic [LENGTH-1:0] shift_q, shift_d;
  logic              tready_q, tready_d;
  logic              chip_q, chip_d;
  logic              chip_valid_q, chip_valid_d;
  logic              code_start_q, code_start_d;
  logic              code_last_q, code_last_d;
  logic              shift_err_q, shift_err_d;

  logic [LENGTH-1:0] k;
  logic              accept;
  logic              lfsr_load;
  logic              m1_step;
  logic              m2_step;
  logic              m1_bit;
  logic              m2_bit;

  assign k      = s_axis.tdata[LENGTH-1:0];
  assign accept = s_axis.tvalid && tready_q;

  gold_lfsr #(.LENGTH(LENGTH), .POLY(POLY1), .SEED(SEED)) u_m1 (
    .clk_i  (clkin),
    .rst_ni (rstn),
    .load_i (lfsr_load),
    .step_i (m1_step),
    .bit0_o (m1_bit)
  );

  gold_lfsr #(.LENGTH(LENGTH), .POLY(POLY2), .SEED(SEED)) u_m2 (
    .clk_i  (clkin),
    .rst_ni (rstn),
    .load_i (lfsr_load),
    .step_i (m2_step),
    .bit0_o (m2_bit)
  );

  // cnt_q serves two purposes. In ALIGN it counts down the remaining m2 advances.
  // In GEN it counts up as the chip index.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    shift_err_d = 1'b0;
    lfsr_load   = 1'b0;
    m1_step     = 1'b0;
    m2_step     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (k <= LAST_IDX) begin
            shift_d   = k;
            lfsr_load = 1'b1;
            cnt_d     = k;
            state_d   = (k == '0) ? GEN : ALIGN;
          end else begin
            shift_err_d = 1'b1;
          end
        end
      end
      ALIGN: begin
        m2_step = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == LENGTH'(1)) begin
          state_d = GEN;
          cnt_d   = '0;
        end
      end
      GEN: begin
        m1_step = 1'b1;
        m2_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The outputs are computed from the next state and the post-edge LFSR bits.
  // This means each registered output describes the cycle that follows the edge.
  always_comb begin
    tready_d     = (state_d == IDLE);
    chip_valid_d = (state_d == GEN);
    chip_d       = chip_valid_d & (m1_bit ^ m2_bit);
    code_start_d = chip_valid_d && (cnt_d == '0);
    code_last_d  = chip_valid_d && (cnt_d == LAST_IDX);
  end

  // State register and registered outputs. Reset aborts any code in flight.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      tready_q     <= 1'b0;
      chip_q       <= 1'b0;
      chip_valid_q <= 1'b0;
      code_start_q <= 1'b0;
      code_last_q  <= 1'b0;
      shift_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      tready_q     <= tready_d;
      chip_q       <= chip_d;
      chip_valid_q <= chip_valid_d;
      code_start_q <= code_start_d;
      code_last_q  <= code_last_d;
      shift_err_q  <= shift_err_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign chip          = chip_q;
  assign chip_valid    = chip_valid_q;
  assign code_start    = code_start_q;
  assign code_last     = code_last_q;
  assign code_shift    = shift_q;
  assign shift_err     = shift_err_q;

`ifdef GOLD_RX_STATS_EN
  logic [LENGTH:0] ones_acc_q;
  logic [LENGTH:0] ones_cnt_q;
  logic            stats_valid_q;

  // The accumulator restarts on code_start. On code_last the final chip is
  // folded in as the total is captured, so the total appears one cycle later.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      ones_acc_q    <= '0;
      ones_cnt_q    <= '0;
      stats_valid_q <= 1'b0;
    end else begin
      stats_valid_q <= code_last_q;
      if (code_start_q) begin
        ones_acc_q <= {{LENGTH{1'b0}}, chip_q};
      end else if (chip_valid_q) begin
        ones_acc_q <= ones_acc_q + {{LENGTH{1'b0}}, chip_q};
      end
      if (code_last_q) begin
        ones_cnt_q <= ones_acc_q + {{LENGTH{1'b0}}, chip_q};
      end
    end
  end

  assign ones_cnt    = ones_cnt_q;
  assign stats_valid = stats_valid_q;
`endif

endmodule

// File: tb/tb_gold_code_receiver.sv
// Self-checking bench for gold_code_receiver.
// The model builds both m-sequences from their recurrences, forms every Gold
// code as m1[i] ^ m2[(i+k) mod N], and predicts the output timeline from
// handshake times alone. The timeline is: first chip at t+1+k, last chip at
// t+k+N, and tready returns on the cycle after the last chip.
module tb_gold_code_receiver;
  import gold_pkg::*;

  localparam int N = 63;
  localparam int L = 6;

  logic clkin = 1'b0;
  logic rstn  = 1'b1;

  always #5 clkin = ~clkin;

  axistream_if #(.DATA_W(8)) axis ();

  logic         chip;
  logic         chip_valid;
  logic         code_start;
  logic         code_last;
  logic [L-1:0] code_shift;
  logic         shift_err;
`ifdef GOLD_RX_STATS_EN
  logic [L:0]   ones_cnt;
  logic         stats_valid;
`endif

  gold_code_receiver dut (
    .clkin       (clkin),
    .rstn        (rstn),
    .s_axis      (axis),
    .chip        (chip),
    .chip_valid  (chip_valid),
    .code_start  (code_start),
    .code_last   (code_last),
    .code_shift  (code_shift),
    .shift_err   (shift_err)
`ifdef GOLD_RX_STATS_EN
    ,
    .ones_cnt    (ones_cnt),
    .stats_valid (stats_valid)
`endif
  );

  int errors = 0;
  int checks = 0;

  bit m1seq [N];
  bit m2seq [N];
  bit gold  [N][N];
  int weight [N];
  int dutWeight [N];

  int tbCyc = 0;
  int lastCodeLastCyc = -10;
  int acceptCyc = 0;
  int dutAcc = 0;

  // Model expectations for the current cycle
  int cyc = 0;
  int firstCyc = 1;
  int lastCyc = 0;
  int codeK = 0;
  bit haveCode = 0;
  bit eReady = 0, eValid = 0, eChip = 0, eStart = 0, eLast = 0, eErr = 0, eStatsValid = 0;
  int eShift = 0;
  int eOnes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, tbCyc, act, exp);
    end
  endtask

  task automatic buildModel();
    logic [L-1:0] seedv;
    logic [L-1:0] p1;
    logic [L-1:0] p2;
    seedv = GOLD_SEED;
    p1 = GOLD_POLY1;
    p2 = GOLD_POLY2;
    for (int i = 0; i < L; i++) begin
      m1seq[i] = seedv[i];
      m2seq[i] = seedv[i];
    end
    for (int n = 0; n + L < N; n++) begin
      bit b1;
      bit b2;
      b1 = 0;
      b2 = 0;
      for (int j = 0; j < L; j++) begin
        if (p1[j]) b1 ^= m1seq[n+j];
        if (p2[j]) b2 ^= m2seq[n+j];
      end
      m1seq[n+L] = b1;
      m2seq[n+L] = b2;
    end
    for (int kk = 0; kk < N; kk++) begin
      weight[kk] = 0;
      dutWeight[kk] = -1;
      for (int i = 0; i < N; i++) begin
        gold[kk][i] = m1seq[i] ^ m2seq[(i + kk) % N];
        weight[kk] += int'(gold[kk][i]);
      end
    end
  endtask

  always @(posedge clkin) tbCyc++;

  // Timeline model, driven only by bench inputs and its own prior expectations
  always @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      cyc = 0; firstCyc = 1; lastCyc = 0; codeK = 0; haveCode = 0;
      eReady = 0; eValid = 0; eChip = 0; eStart = 0; eLast = 0; eErr = 0;
      eShift = 0; eStatsValid = 0; eOnes = 0;
    end else begin
      int kin;
      int idx;
      cyc++;
      eErr = 0;
      if (axis.tvalid && eReady) begin
        kin = int'(axis.tdata[L-1:0]);
        if (kin >= N) begin
          eErr = 1;
        end else begin
          codeK = kin; eShift = kin; haveCode = 1;
          firstCyc = cyc + kin;
          lastCyc = firstCyc + N - 1;
        end
      end
      eStatsValid = haveCode && (cyc == lastCyc + 1);
      eOnes = weight[codeK];
      eReady = (cyc > lastCyc);
      eValid = (cyc >= firstCyc) && (cyc <= lastCyc);
      idx = cyc - firstCyc;
      eChip = 0; eStart = 0; eLast = 0;
      if (eValid) begin
        eChip = gold[codeK][idx];
        eStart = (idx == 0);
        eLast = (idx == N - 1);
      end
    end
  end

  // Per-cycle compare and DUT code-weight capture
  always @(negedge clkin) begin
    checkOutput("tready", axis.tready, eReady);
    checkOutput("chip_valid", chip_valid, eValid);
    checkOutput("code_start", code_start, eStart);
    checkOutput("code_last", code_last, eLast);
    checkOutput("shift_err", shift_err, eErr);
    checkOutput("code_shift", code_shift, eShift);
    if (eValid) checkOutput("chip", chip, eChip);
`ifdef GOLD_RX_STATS_EN
    checkOutput("stats_valid", stats_valid, eStatsValid);
    if (eStatsValid) checkOutput("ones_cnt", ones_cnt, eOnes);
`endif
    if (chip_valid === 1'b1) begin
      dutAcc = (code_start === 1'b1) ? int'(chip) : dutAcc + int'(chip);
      if (code_last === 1'b1) begin
        dutWeight[code_shift] = dutAcc;
        lastCodeLastCyc = tbCyc;
      end
    end
  end

  // Offer a word and hold it until the DUT takes it. Returns at the negedge after the handshake.
  task automatic applyStimulus(input logic [7:0] word);
    bit done;
    done = 0;
    axis.tvalid = 1'b1;
    axis.tdata = word;
    for (int i = 0; i < 400 && !done; i++) begin
      if (axis.tready === 1'b1) begin
        acceptCyc = tbCyc;
        done = 1;
      end
      @(negedge clkin);
    end
    if (!done) checkOutput("handshake_timeout", 0, 1);
    axis.tvalid = 1'b0;
  endtask

  task automatic waitReady();
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (axis.tready === 1'b1) done = 1;
      else @(negedge clkin);
    end
    if (!done) checkOutput("ready_timeout", 0, 1);
  endtask

  initial begin
    int cnt;
    int dups;
    int inSet;
    axis.tvalid = 1'b0;
    axis.tdata = '0;
    buildModel();

    // Hand-derived values that pin the model
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m1seq[i]);
    checkOutput("m1_weight", cnt, 32);
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m2seq[i]);
    checkOutput("m2_weight", cnt, 32);
    checkOutput("gold0_chip0", gold[0][0], 0);
    checkOutput("gold0_chip6", gold[0][6], 0);
    checkOutput("gold0_chip7", gold[0][7], 0);
    checkOutput("gold0_chip8", gold[0][8], 1);
    checkOutput("gold5_chip0", gold[5][0], 0);
    checkOutput("gold5_chip1", gold[5][1], 1);
    checkOutput("gold5_chip2", gold[5][2], 0);
    checkOutput("gold5_chip3", gold[5][3], 0);

    #1 rstn = 1'b0;
    repeat (3) @(negedge clkin);
    checkOutput("reset_tready", axis.tready, 0);
    checkOutput("reset_chip_valid", chip_valid, 0);
    checkOutput("reset_code_shift", code_shift, 0);
    rstn = 1'b1;
    @(negedge clkin);
    checkOutput("ready_after_release", axis.tready, 1);

    // k=0: the first chip appears on the cycle right after the handshake
    applyStimulus(8'd0);
    checkOutput("k0_first_valid", chip_valid, 1);
    checkOutput("k0_first_start", code_start, 1);
    checkOutput("k0_first_chip", chip, 0);
    waitReady();

    // k=5: five quiet ALIGN cycles, then the code starts
    applyStimulus(8'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("k5_align_quiet", chip_valid, 0);
      @(negedge clkin);
    end
    checkOutput("k5_first_valid", chip_valid, 1);
    checkOutput("k5_first_start", code_start, 1);
    checkOutput("k5_chip0", chip, 0);
    checkOutput("k5_shift", code_shift, 5);
    @(negedge clkin);
    checkOutput("k5_chip1", chip, 1);
    waitReady();

    // Upper tdata bits are ignored: 0xC3 means k=3
    applyStimulus(8'hC3);
    checkOutput("upper_bits_shift", code_shift, 3);
    waitReady();

    // Illegal k=63: a single error pulse, no code, and a later legal word is accepted
    applyStimulus(8'd63);
    checkOutput("k63_err_pulse", shift_err, 1);
    checkOutput("k63_ready", axis.tready, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clkin);
      cnt += int'(shift_err) + int'(chip_valid);
    end
    checkOutput("k63_quiet_after", cnt, 0);
    applyStimulus(8'd1);
    checkOutput("k1_after_err_shift", code_shift, 1);
    waitReady();

    // tvalid held through a code: k=3 is taken on the IDLE cycle right after code_last
    applyStimulus(8'd20);
    applyStimulus(8'd3);
    checkOutput("held_accept_cycle", acceptCyc, lastCodeLastCyc + 1);
    waitReady();

    // Sweep every legal shift
    for (int kk = 0; kk < N; kk++) begin
      waitReady();
      applyStimulus(8'(kk));
    end
    waitReady();
    @(negedge clkin);
    for (int kk = 0; kk < N; kk++) begin
      inSet = (dutWeight[kk] == 24 || dutWeight[kk] == 32 || dutWeight[kk] == 40) ? 1 : 0;
      checkOutput("sweep_weight_set", inSet, 1);
      checkOutput("sweep_weight_model", dutWeight[kk], weight[kk]);
    end
    dups = 0;
    for (int a = 0; a < N; a++) begin
      for (int b = a + 1; b < N; b++) begin
        bit same;
        same = 1;
        for (int i = 0; i < N; i++) if (gold[a][i] != gold[b][i]) same = 0;
        if (same) dups++;
      end
    end
    checkOutput("codes_distinct", dups, 0);

    // Reset in the middle of chip 30 of k=10
    waitReady();
    applyStimulus(8'd10);
    repeat (40) @(negedge clkin);
    checkOutput("mid_code_valid", chip_valid, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("abort_chip_valid", chip_valid, 0);
    checkOutput("abort_chip", chip, 0);
    checkOutput("abort_code_shift", code_shift, 0);
    checkOutput("abort_tready", axis.tready, 0);
    @(negedge clkin);
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clkin);
      cnt += int'(chip_valid);
    end
    checkOutput("no_residual_chips", cnt, 0);
    checkOutput("ready_after_abort", axis.tready, 1);

    applyStimulus(8'd7);
    waitReady();
    @(negedge clkin);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gold_code_receiver.md
Name: gold_code_receiver

Overview:
- AXI-stream slave at the far end of the Gold-shift generator link.
- Accepts one shift word k per handshake. For each accepted k, produces one full N-chip Gold code serially, one chip per clock: m1 XOR (m2 advanced by k).
- Feeds the spreading / correlator datapath downstream. No output backpressure: the consumer takes every chip while chip_valid is high.

Parameters:
- N, 63, code length (2^LENGTH - 1).
- LENGTH, $clog2(N), LFSR degree and shift-word width.
- POLY1, 6'b100001, feedback taps of m1 (x^6+x+1), LENGTH bits.
- POLY2, 6'b110011, feedback taps of m2 (x^6+x^5+x^2+x+1), LENGTH bits.
- SEED, all-ones, load value for both LFSRs; must be non-zero.

Ports:
- clkin  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- s_axis  axistream_if.slave  —  shift-word input; uses tvalid, tready, tdata.
  - tdata[LENGTH-1:0] carries k; upper bits are ignored.
- chip  output  1  current Gold chip.
- chip_valid  output  1  chip is valid this cycle.
- code_start  output  1  marks chip index 0.
- code_last  output  1  marks chip index N-1.
- code_shift  output  LENGTH  k of the code currently being output; held until the next accept.
- shift_err  output  1  one-cycle pulse when an illegal k (k >= N) is accepted.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State returns to IDLE; both LFSRs load SEED.
  - tready=0; chip, chip_valid, code_start, code_last, shift_err = 0; code_shift = 0.
  - All outputs are registered. Reset mid-code aborts at once; no partial tail is emitted after release.
- FSM IDLE:
  - tready=1.
  - On tvalid&&tready with k < N: latch k into code_shift, reload both LFSRs with SEED, load the align counter with k. Next state is ALIGN if k > 0, else GEN.
  - On k >= N: pulse shift_err the next cycle, stay in IDLE, generate nothing, leave code_shift unchanged.
- FSM ALIGN:
  - tready=0.
  - m2 steps once per cycle; m1 holds. The counter decrements.
  - Exit to GEN on the cycle the counter reaches 1 (exactly k steps).
- FSM GEN:
  - tready=0. Both LFSRs step each cycle. chip = m1[0] ^ m2[0], chip_valid=1.
  - Chip counter runs 0..N-1: code_start when it is 0, code_last when it is N-1.
  - After chip N-1, go to IDLE; chip_valid drops the following cycle.
- LFSR step: Fibonacci form.
  - new_bit = ^(reg & POLY); reg <= {new_bit, reg[LENGTH-1:1]}.
  - Output bit is reg[0].
- Latency: handshake at cycle t gives the first chip at t+1+k and the last at t+k+N.
- tvalid asserted while not in IDLE is ignored (tready=0); the upstream master holds it.
- Back-to-back codes: the next handshake can occur in the IDLE cycle after code_last, giving a one-cycle gap between codes.
- Counters are LENGTH bits wide; no wrap is possible because k < N is enforced.

Optional Feature:
- Macro GOLD_RX_STATS_EN.
- Defined:
  - Extra output ones_cnt (LENGTH+1 bits) counts 1-chips in the current code.
  - Registered value presented with one-cycle stats_valid pulse on the cycle after code_last.
  - Counter clears at code_start.
- Undefined: no ports, no logic; behaviour otherwise identical.

Decomposition:
- Package gold_pkg:
  - typedef shift_t (logic [LENGTH-1:0]).
  - State enum {IDLE, ALIGN, GEN}.
  - Default POLY1/POLY2/SEED constants.
- Sub-module gold_lfsr (params LENGTH, POLY, SEED; inputs load, step; output bit0):
  - instantiated twice, for m1 and m2.

Test Plan:
- Reset release, send k=0 -> first chip appears t+1 with value 0 (1^1), code_start with it; 63 chips follow, code_last on chip 62, chip_valid low after.
- k=5 -> 5-cycle ALIGN with chip_valid=0; first chip at t+6. Sequence matches a reference model m1 ^ (m2 advanced 5); code_shift=5 throughout.
- Sweep k=0..62 -> each code's ones count is in {24,32,40}; every pair of codes differs. With GOLD_RX_STATS_EN, ones_cnt agrees.
- k=63 -> shift_err pulses once, no chip_valid, tready stays 1; next k=1 is accepted normally.
- tvalid held high during GEN with k=3 pending -> not accepted until IDLE; code k=3 starts exactly 1 cycle after the previous code_last+1.
- rstn pulsed low at chip 30 of k=10 -> all outputs 0 immediately. After release, tready=1 and no residual chips appear.
